// File: rtl/autoconfig_host_if.sv
// Bus-master port of the AutoConfig host: request/acknowledge nibble cycles
// into the E8xxxx configuration window.
interface autoconfig_host_if;
   logic        bus_req;
   logic        bus_ack;
   logic        bus_rw;
   logic [22:0] bus_addr;
   logic [3:0]  bus_dout;
   logic [3:0]  bus_din;

   modport master (
      output bus_req,
      output bus_rw,
      output bus_addr,
      output bus_dout,
      input  bus_ack,
      input  bus_din
   );

   modport slave (
      input  bus_req,
      input  bus_rw,
      input  bus_addr,
      input  bus_dout,
      output bus_ack,
      output bus_din
   );
endinterface

// File: rtl/autoconfig_host.sv
// Zorro II AutoConfig initiator: walks the E8 window after start, reads each
// card's config nibbles, allocates a Z2 RAM or IO base (or shuts the card up)
// and emits one record per board.
module autoconfig_host #(
   parameter int unsigned MAX_BOARDS = 8,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                CLK,
   input  logic                RESET_n,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                timeout_err,
   autoconfig_host_if.master   bus,
   output logic                rec_valid,
   output logic [15:0]         rec_mfg,
   output logic [7:0]          rec_prod,
   output logic [7:0]          rec_base,
   output logic [2:0]          rec_size,
   output logic                rec_mem,
   output logic                rec_shutup,
   output logic [3:0]          board_count
);

   localparam int unsigned TMO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [7:0]  CFG_HI    = 8'hE8;
   localparam logic [7:0]  MEM_START = 8'h20;
   localparam logic [7:0]  IO_START  = 8'hE9;
   localparam logic [9:0]  MEM_LIMIT = 10'h0A0;
   localparam logic [9:0]  IO_LIMIT  = 10'h0F0;
   localparam logic [7:0]  IDX_WR_HI = 8'h24;
   localparam logic [7:0]  IDX_WR_LO = 8'h25;
   localparam logic [7:0]  IDX_SHUT  = 8'h26;
   localparam logic [3:0]  RD_LAST   = 4'd9;
   localparam logic [4:0]  MAX_CNT   = 5'(MAX_BOARDS);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_ALLOC, S_WR_LO, S_WR_HI, S_SHUTUP, S_REPORT, S_DONE
   } state_t;

   // 64KB units for each raw size code; code 0 is 8MB
   function automatic logic [8:0] size_units(input logic [2:0] code);
      if (code == 3'd0) return 9'd128;
      return 9'(9'd1 << (code - 3'd1));
   endfunction

   // read position 0..9 -> nibble index 00-05, 08-0B
   function automatic logic [7:0] rd_index(input logic [3:0] pos);
      if (pos < 4'd6) return {4'h0, pos};
      return {4'h0, 4'(pos + 4'd2)};
   endfunction

   state_t           state_q, state_d;
   logic [3:0]       pos_q, pos_d;
   logic             req_q, req_d;
   logic             rw_q, rw_d;
   logic [22:0]      addr_q, addr_d;
   logic [3:0]       dout_q, dout_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             mem_q, mem_d;
   logic [2:0]       size_q, size_d;
   logic [7:0]       prod_q, prod_d;
   logic [15:0]      mfg_q, mfg_d;
   logic [7:0]       base_q, base_d;
   logic             shut_q, shut_d;
   logic [7:0]       mem_ptr_q, mem_ptr_d;
   logic [7:0]       io_ptr_q, io_ptr_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             tmo_err_q, tmo_err_d;
   logic             rec_valid_q, rec_valid_d;
   logic [15:0]      rec_mfg_q, rec_mfg_d;
   logic [7:0]       rec_prod_q, rec_prod_d;
   logic [7:0]       rec_base_q, rec_base_d;
   logic [2:0]       rec_size_q, rec_size_d;
   logic             rec_mem_q, rec_mem_d;
   logic             rec_shut_q, rec_shut_d;
   logic [3:0]       cnt_q, cnt_d;

   logic [8:0]       size_w;
   logic [7:0]       ptr_w;
   logic [9:0]       limit_w;
   logic [8:0]       round_w;
   logic [9:0]       end_w;
   logic [7:0]       base_w;
   logic             fit_w;

   logic             bus_st_c;
   logic [7:0]       bus_idx_c;
   logic             bus_rw_c;
   logic [3:0]       bus_wd_c;

   // base allocation: round the pool pointer up to the board's size and test fit
   always_comb begin
      size_w  = size_units(size_q);
      ptr_w   = mem_q ? mem_ptr_q : io_ptr_q;
      limit_w = mem_q ? MEM_LIMIT : IO_LIMIT;
      round_w = 9'({1'b0, ptr_w} + size_w - 9'd1) & ~(size_w - 9'd1);
      end_w   = {1'b0, round_w} + {1'b0, size_w};
      base_w  = round_w[7:0];
      fit_w   = (end_w <= limit_w);
      if (size_q == 3'd0) begin
         // 8MB only fits as the very first memory board
         base_w = MEM_START;
         fit_w  = mem_q && (mem_ptr_q == MEM_START);
      end
   end

   // next-state, bus-cycle engine and record outputs
   always_comb begin
      state_d     = state_q;
      pos_d       = pos_q;
      req_d       = req_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      dout_d      = dout_q;
      tmo_d       = tmo_q;
      mem_d       = mem_q;
      size_d      = size_q;
      prod_d      = prod_q;
      mfg_d       = mfg_q;
      base_d      = base_q;
      shut_d      = shut_q;
      mem_ptr_d   = mem_ptr_q;
      io_ptr_d    = io_ptr_q;
      busy_d      = busy_q;
      done_d      = done_q;
      tmo_err_d   = tmo_err_q;
      rec_valid_d = 1'b0;
      rec_mfg_d   = rec_mfg_q;
      rec_prod_d  = rec_prod_q;
      rec_base_d  = rec_base_q;
      rec_size_d  = rec_size_q;
      rec_mem_d   = rec_mem_q;
      rec_shut_d  = rec_shut_q;
      cnt_d       = cnt_q;
      bus_st_c    = 1'b0;
      bus_idx_c   = 8'h00;
      bus_rw_c    = 1'b1;
      bus_wd_c    = 4'h0;

      unique case (state_q)
         // a start from DONE restarts directly, as if passing through IDLE
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_READ;
               pos_d     = 4'd0;
               cnt_d     = 4'd0;
               mem_ptr_d = MEM_START;
               io_ptr_d  = IO_START;
               tmo_err_d = 1'b0;
               busy_d    = 1'b1;
               done_d    = 1'b0;
            end
         end
         S_READ: begin
            bus_st_c  = 1'b1;
            bus_idx_c = rd_index(pos_q);
         end
         S_ALLOC: begin
            base_d  = base_w;
            shut_d  = !fit_w;
            state_d = fit_w ? S_WR_LO : S_SHUTUP;
         end
         S_WR_LO: begin
            bus_st_c  = 1'b1;
            bus_idx_c = IDX_WR_LO;
            bus_rw_c  = 1'b0;
            bus_wd_c  = base_q[3:0];
         end
         S_WR_HI: begin
            bus_st_c  = 1'b1;
            bus_idx_c = IDX_WR_HI;
            bus_rw_c  = 1'b0;
            bus_wd_c  = base_q[7:4];
         end
         S_SHUTUP: begin
            bus_st_c  = 1'b1;
            bus_idx_c = IDX_SHUT;
            bus_rw_c  = 1'b0;
         end
         S_REPORT: begin
            rec_valid_d = 1'b1;
            rec_mfg_d   = mfg_q;
            rec_prod_d  = prod_q;
            rec_base_d  = shut_q ? 8'h00 : base_q;
            rec_size_d  = size_q;
            rec_mem_d   = mem_q;
            rec_shut_d  = shut_q;
            cnt_d       = cnt_q + 4'd1;
            if (({1'b0, cnt_q} + 5'd1) >= MAX_CNT) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = S_READ;
               pos_d   = 4'd0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // one bus cycle per bus state: raise, hold until ack or timeout, drop
      if (bus_st_c) begin
         if (!req_q) begin
            req_d  = 1'b1;
            addr_d = {CFG_HI, 7'd0, bus_idx_c};
            rw_d   = bus_rw_c;
            dout_d = bus_wd_c;
            tmo_d  = '0;
         end else if (bus.bus_ack) begin
            req_d = 1'b0;
            unique case (state_q)
               S_READ: begin
                  unique case (pos_q)
                     4'd0: mem_d = bus.bus_din[1];
                     4'd1: size_d = bus.bus_din[2:0];
                     4'd2: prod_d[7:4] = ~bus.bus_din;
                     4'd3: prod_d[3:0] = ~bus.bus_din;
                     4'd6: mfg_d[15:12] = ~bus.bus_din;
                     4'd7: mfg_d[11:8] = ~bus.bus_din;
                     4'd8: mfg_d[7:4] = ~bus.bus_din;
                     4'd9: mfg_d[3:0] = ~bus.bus_din;
                     default: ;
                  endcase
                  if ((pos_q == 4'd0) && (bus.bus_din[3:2] != 2'b11)) begin
                     state_d = S_DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else if (pos_q == RD_LAST) begin
                     state_d = S_ALLOC;
                     pos_d   = 4'd0;
                  end else begin
                     pos_d = pos_q + 4'd1;
                  end
               end
               S_WR_LO: state_d = S_WR_HI;
               S_WR_HI: begin
                  if (mem_q) mem_ptr_d = base_q + size_w[7:0];
                  else       io_ptr_d  = base_q + size_w[7:0];
                  state_d = S_REPORT;
               end
               S_SHUTUP: state_d = S_REPORT;
               default: ;
            endcase
         end else if (tmo_q == TMO_LAST) begin
            req_d     = 1'b0;
            tmo_err_d = 1'b1;
            state_d   = S_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   // state and output registers
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q     <= S_IDLE;
         pos_q       <= 4'd0;
         req_q       <= 1'b0;
         rw_q        <= 1'b0;
         addr_q      <= 23'h740000;
         dout_q      <= 4'h0;
         tmo_q       <= '0;
         mem_q       <= 1'b0;
         size_q      <= 3'd0;
         prod_q      <= 8'h00;
         mfg_q       <= 16'h0000;
         base_q      <= 8'h00;
         shut_q      <= 1'b0;
         mem_ptr_q   <= MEM_START;
         io_ptr_q    <= IO_START;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         tmo_err_q   <= 1'b0;
         rec_valid_q <= 1'b0;
         rec_mfg_q   <= 16'h0000;
         rec_prod_q  <= 8'h00;
         rec_base_q  <= 8'h00;
         rec_size_q  <= 3'd0;
         rec_mem_q   <= 1'b0;
         rec_shut_q  <= 1'b0;
         cnt_q       <= 4'd0;
      end else begin
         state_q     <= state_d;
         pos_q       <= pos_d;
         req_q       <= req_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         dout_q      <= dout_d;
         tmo_q       <= tmo_d;
         mem_q       <= mem_d;
         size_q      <= size_d;
         prod_q      <= prod_d;
         mfg_q       <= mfg_d;
         base_q      <= base_d;
         shut_q      <= shut_d;
         mem_ptr_q   <= mem_ptr_d;
         io_ptr_q    <= io_ptr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         tmo_err_q   <= tmo_err_d;
         rec_valid_q <= rec_valid_d;
         rec_mfg_q   <= rec_mfg_d;
         rec_prod_q  <= rec_prod_d;
         rec_base_q  <= rec_base_d;
         rec_size_q  <= rec_size_d;
         rec_mem_q   <= rec_mem_d;
         rec_shut_q  <= rec_shut_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.bus_req  = req_q;
   assign bus.bus_rw   = rw_q;
   assign bus.bus_addr = addr_q;
   assign bus.bus_dout = dout_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign timeout_err  = tmo_err_q;
   assign rec_valid    = rec_valid_q;
   assign rec_mfg      = rec_mfg_q;
   assign rec_prod     = rec_prod_q;
   assign rec_base     = rec_base_q;
   assign rec_size     = rec_size_q;
   assign rec_mem      = rec_mem_q;
   assign rec_shutup   = rec_shut_q;
   assign board_count  = cnt_q;

endmodule

// File: tb/tb_autoconfig_host.sv
// Bench for autoconfig_host: a card-chain responder answers the E8 window
// from a board table; a reference model predicts records and config writes.
module tb_autoconfig_host;

   localparam int unsigned MAXB = 2;
   localparam int unsigned TMO  = 20;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        busy, done, timeout_err;
   logic        rec_valid, rec_mem, rec_shutup;
   logic [15:0] rec_mfg;
   logic [7:0]  rec_prod, rec_base;
   logic [2:0]  rec_size;
   logic [3:0]  board_count;

   autoconfig_host_if bus_if();

   autoconfig_host #(.MAX_BOARDS(MAXB), .TIMEOUT(TMO)) dut (
      .CLK(clk), .RESET_n(rst_n), .start(start),
      .busy(busy), .done(done), .timeout_err(timeout_err),
      .bus(bus_if),
      .rec_valid(rec_valid), .rec_mfg(rec_mfg), .rec_prod(rec_prod),
      .rec_base(rec_base), .rec_size(rec_size), .rec_mem(rec_mem),
      .rec_shutup(rec_shutup), .board_count(board_count)
   );

   typedef struct packed {
      logic [15:0] mfg;
      logic [7:0]  prod;
      logic [7:0]  base;
      logic [2:0]  size;
      logic        mem;
      logic        shut;
   } rec_t;

   rec_t        got_recs[$];
   rec_t        exp_recs[$];
   logic [11:0] got_wr[$];
   logic [11:0] exp_wr[$];

   logic [7:0]  b_type[8];
   logic [7:0]  b_prod[8];
   logic [15:0] b_mfg[8];
   int          nb;
   int          cur;
   int          n_tests;
   int          n_fail;
   int          viol;
   int          hi_cnt;
   int          last_hi;
   int          wait_cnt;
   int          first_idx;
   bit          resp_en;
   bit          hold_wrhi;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // raw nibble a card presents at config index idx; absent card reads 0
   function automatic logic [3:0] nib(input int c, input logic [7:0] idx);
      logic [7:0]  t;
      logic [7:0]  p;
      logic [15:0] m;
      if (c >= nb) return 4'h0;
      t = b_type[c];
      p = b_prod[c];
      m = b_mfg[c];
      case (idx)
         8'h00: return t[7:4];
         8'h01: return t[3:0];
         8'h02: return ~p[7:4];
         8'h03: return ~p[3:0];
         8'h08: return ~m[15:12];
         8'h09: return ~m[11:8];
         8'h0A: return ~m[7:4];
         8'h0B: return ~m[3:0];
         default: return 4'hF;
      endcase
   endfunction

   // card chain: answer reads, log writes, advance to next card on configure/shut-up
   initial begin
      bus_if.bus_ack = 1'b0;
      bus_if.bus_din = 4'h0;
      wait_cnt = 0;
      forever begin
         @(negedge clk);
         if (bus_if.bus_ack) begin
            bus_if.bus_ack = 1'b0;
         end else if (rst_n && resp_en && bus_if.bus_req &&
                      !(hold_wrhi && bus_if.bus_addr[7:0] == 8'h24)) begin
            if (wait_cnt > 0) begin
               wait_cnt--;
            end else begin
               if (first_idx < 0) first_idx = int'(bus_if.bus_addr[7:0]);
               if (bus_if.bus_rw) begin
                  bus_if.bus_din = nib(cur, bus_if.bus_addr[7:0]);
               end else begin
                  got_wr.push_back({bus_if.bus_addr[7:0], bus_if.bus_dout});
                  if (bus_if.bus_addr[7:0] == 8'h24 || bus_if.bus_addr[7:0] == 8'h26) cur++;
               end
               bus_if.bus_ack = 1'b1;
               wait_cnt = int'($urandom_range(0, 3));
            end
         end
      end
   end

   // protocol monitor and record capture, sampled just after each rising edge
   initial begin
      logic        prev_req;
      logic [27:0] prev_bus;
      rec_t        r;
      prev_req = 1'b0;
      prev_bus = '0;
      hi_cnt   = 0;
      last_hi  = 0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst_n) begin
            prev_req = 1'b0;
            hi_cnt   = 0;
         end else begin
            if (prev_req && bus_if.bus_ack && bus_if.bus_req) viol++;
            if (prev_req && bus_if.bus_req &&
                {bus_if.bus_addr, bus_if.bus_rw, bus_if.bus_dout} != prev_bus) viol++;
            if (bus_if.bus_req && bus_if.bus_addr[22:8] != 15'h7400) viol++;
            if (bus_if.bus_req) begin
               hi_cnt++;
            end else begin
               if (prev_req) last_hi = hi_cnt;
               hi_cnt = 0;
            end
            if (rec_valid) begin
               r = {rec_mfg, rec_prod, rec_base, rec_size, rec_mem, rec_shutup};
               got_recs.push_back(r);
            end
            prev_req = bus_if.bus_req;
            prev_bus = {bus_if.bus_addr, bus_if.bus_rw, bus_if.bus_dout};
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_board(input int i, input logic [7:0] t, input logic [7:0] p,
                            input logic [15:0] m);
      b_type[i] = t;
      b_prod[i] = p;
      b_mfg[i]  = m;
   endtask

   // expected records and config writes from the allocation rules
   task automatic build_model();
      int         mptr, iptr, sz, base, lim, ptr;
      bit         mem, fit;
      logic [2:0] code;
      rec_t       r;
      exp_recs.delete();
      exp_wr.delete();
      mptr = 32'h20;
      iptr = 32'hE9;
      for (int b = 0; b < int'(MAXB); b++) begin
         if (b >= nb || b_type[b][7:6] != 2'b11) break;
         mem  = b_type[b][5];
         code = b_type[b][2:0];
         sz   = (code == 3'd0) ? 128 : (1 << (int'(code) - 1));
         if (code == 3'd0) begin
            fit  = mem && (mptr == 32'h20);
            base = 32'h20;
         end else begin
            ptr  = mem ? mptr : iptr;
            lim  = mem ? 32'hA0 : 32'hF0;
            base = ((ptr + sz - 1) / sz) * sz;
            fit  = (base + sz) <= lim;
         end
         r.mfg  = b_mfg[b];
         r.prod = b_prod[b];
         r.base = fit ? 8'(base) : 8'h00;
         r.size = code;
         r.mem  = mem;
         r.shut = !fit;
         exp_recs.push_back(r);
         if (fit) begin
            exp_wr.push_back({8'h25, 4'(base % 16)});
            exp_wr.push_back({8'h24, 4'(base / 16)});
            if (mem) mptr = base + sz;
            else     iptr = base + sz;
         end else begin
            exp_wr.push_back({8'h26, 4'h0});
         end
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (!done && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk({tag, ":done"}, 64'(done), 64'd1);
   endtask

   task automatic run_scn(input string tag, input int spurious);
      got_recs.delete();
      got_wr.delete();
      cur       = 0;
      viol      = 0;
      first_idx = -1;
      build_model();
      pulse_start();
      chk({tag, ":busy"}, 64'(busy), 64'd1);
      if (spurious > 0) begin
         repeat (spurious) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_done(tag);
      @(negedge clk);
      chk({tag, ":nrec"}, 64'(got_recs.size()), 64'(exp_recs.size()));
      for (int i = 0; i < got_recs.size() && i < exp_recs.size(); i++)
         chk($sformatf("%s:rec%0d", tag, i), 64'(got_recs[i]), 64'(exp_recs[i]));
      chk({tag, ":nwr"}, 64'(got_wr.size()), 64'(exp_wr.size()));
      for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
         chk($sformatf("%s:wr%0d", tag, i), 64'(got_wr[i]), 64'(exp_wr[i]));
      chk({tag, ":count"}, 64'(board_count), 64'(exp_recs.size()));
      chk({tag, ":busy_end"}, 64'(busy), 64'd0);
      chk({tag, ":tmo_err"}, 64'(timeout_err), 64'd0);
      chk({tag, ":protocol"}, 64'(viol), 64'd0);
   endtask

   initial begin
      int k;
      n_tests   = 0;
      n_fail    = 0;
      viol      = 0;
      nb        = 0;
      cur       = 0;
      first_idx = -1;
      resp_en   = 1'b1;
      hold_wrhi = 1'b0;
      rst_n     = 1'b0;
      start     = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("rst:req", 64'(bus_if.bus_req), 64'd0);
      chk("rst:addr", 64'(bus_if.bus_addr), 64'h740000);
      chk("rst:busy", 64'(busy), 64'd0);
      chk("rst:done", 64'(done), 64'd0);
      chk("rst:count", 64'(board_count), 64'd0);
      chk("rst:recv", 64'(rec_valid), 64'd0);

      // RAM-then-IO
      set_board(0, 8'hE0, 8'd72, 16'h07DB);
      set_board(1, 8'hC1, 8'h49, 16'h1234);
      nb = 2;
      run_scn("ramio", 0);
      chk("ramio:base0", 64'(got_recs[0].base), 64'h20);
      chk("ramio:mem0", 64'(got_recs[0].mem), 64'd1);
      chk("ramio:base1", 64'(got_recs[1].base), 64'hE9);
      chk("ramio:wr1", 64'(got_wr[1]), 64'h242);
      chk("ramio:wr2", 64'(got_wr[2]), 64'h259);
      chk("ramio:wr3", 64'(got_wr[3]), 64'h24E);

      // end of chain detection
      nb = 1;
      run_scn("oneboard", 0);
      nb = 0;
      run_scn("noboard", 0);

      // alignment, with a start pulse while busy
      set_board(0, 8'hE1, 8'h10, 16'h0202);
      set_board(1, 8'hE4, 8'h11, 16'h0303);
      nb = 2;
      run_scn("align", 5);
      chk("align:base0", 64'(got_recs[0].base), 64'h20);
      chk("align:base1", 64'(got_recs[1].base), 64'h28);

      // memory pool exhaustion
      set_board(0, 8'hE0, 8'h20, 16'h0404);
      set_board(1, 8'hE5, 8'h21, 16'h0505);
      nb = 2;
      run_scn("exhaust", 0);
      chk("exhaust:shut", 64'(got_recs[1].shut), 64'd1);
      chk("exhaust:base", 64'(got_recs[1].base), 64'h00);
      chk("exhaust:wr", 64'(got_wr[2]), 64'h260);

      // board limit
      set_board(0, 8'hC1, 8'h30, 16'h0606);
      set_board(1, 8'hC1, 8'h31, 16'h0606);
      set_board(2, 8'hC1, 8'h32, 16'h0606);
      nb = 3;
      run_scn("maxb", 0);
      chk("maxb:base0", 64'(got_recs[0].base), 64'hE9);
      chk("maxb:base1", 64'(got_recs[1].base), 64'hEA);

      // timeout on the first read
      resp_en = 1'b0;
      got_recs.delete();
      pulse_start();
      wait_done("tmo");
      @(negedge clk);
      chk("tmo:req_len", 64'(last_hi), 64'(TMO));
      chk("tmo:req", 64'(bus_if.bus_req), 64'd0);
      chk("tmo:err", 64'(timeout_err), 64'd1);
      chk("tmo:count", 64'(board_count), 64'd0);
      chk("tmo:nrec", 64'(got_recs.size()), 64'd0);
      resp_en = 1'b1;

      // reset while the WR_HI cycle is outstanding
      set_board(0, 8'hC1, 8'h40, 16'h0707);
      set_board(1, 8'hC1, 8'h41, 16'h0707);
      nb = 2;
      cur = 0;
      hold_wrhi = 1'b1;
      pulse_start();
      k = 0;
      while (!(bus_if.bus_req && bus_if.bus_addr[7:0] == 8'h24) && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("rstmid:reach_wrhi", 64'(k < 500), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid:req", 64'(bus_if.bus_req), 64'd0);
      chk("rstmid:addr", 64'(bus_if.bus_addr), 64'h740000);
      chk("rstmid:rw", 64'(bus_if.bus_rw), 64'd0);
      chk("rstmid:busy", 64'(busy), 64'd0);
      chk("rstmid:count", 64'(board_count), 64'd0);
      chk("rstmid:recbase", 64'(rec_base), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      hold_wrhi = 1'b0;
      @(negedge clk);
      run_scn("rerun", 0);
      chk("rerun:first_idx", 64'(first_idx), 64'd0);

      // randomized board chains
      for (int it = 0; it < 12; it++) begin
         nb = int'($urandom_range(0, 3));
         for (int b = 0; b < nb; b++) begin
            logic [7:0] t;
            t = 8'($urandom);
            t[7:6] = ($urandom_range(0, 9) == 0) ? 2'b01 : 2'b11;
            set_board(b, t, 8'($urandom), 16'($urandom));
         end
         run_scn($sformatf("rand%0d", it), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
